// File: rtl/adam_tgt_maestro.sv
// Per-target lifecycle sequencer: consumes MR actions, drives target pause/reset.
// Optional ack-wait timeout enabled by defining ADAM_MAESTRO_TIMEOUT_EN.
module adam_tgt_maestro #(
    parameter int DATA_WIDTH   = 32,
    parameter int RST_CYCLES   = 4,
    parameter int BOOT_RUNNING = 1,
    parameter int TIMEOUT      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mr_we,
    input  logic [DATA_WIDTH-1:0] mr_wdata,
    output logic [DATA_WIDTH-1:0] mr_rdata,
    output logic [DATA_WIDTH-1:0] sr_rdata,
    input  logic                  pause_req,
    output logic                  pause_ack,
    output logic                  tgt_rst,
    output logic                  tgt_pause_req,
    input  logic                  tgt_pause_ack
);

    localparam int CW = $clog2(RST_CYCLES + 1);

    localparam logic [1:0] ACT_NONE   = 2'd0;
    localparam logic [1:0] ACT_RESUME = 2'd1;
    localparam logic [1:0] ACT_PAUSE  = 2'd2;
    localparam logic [1:0] ACT_STOP   = 2'd3;

    if (RST_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("adam_tgt_maestro: RST_CYCLES and TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {
        STOPPED   = 3'd0,
        RUNNING   = 3'd1,
        PAUSED    = 3'd2,
        PAUSING   = 3'd3,
        UNRESET   = 3'd4,
        UNPAUSING = 3'd5,
        RESETTING = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     act_q, act_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           pause_ack_q, pause_ack_d;
    logic           tgt_rst_q, tgt_rst_d;
    logic           tgt_preq_q, tgt_preq_d;
    logic           wr_valid, wr_ok;
    logic [1:0]     act;
    logic           expire;
    logic           err;

    assign wr_valid = mr_we && (mr_wdata[DATA_WIDTH-1:2] == '0)
                      && (mr_wdata[1:0] != ACT_NONE);
    assign wr_ok    = wr_valid && (act_q == ACT_NONE) && !pause_ack_q;
    assign act      = wr_ok ? mr_wdata[1:0] : act_q;

`ifdef ADAM_MAESTRO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt_q;
    logic          err_q;
    logic          waiting;

    assign waiting = (state_q == PAUSING   && !tgt_pause_ack)
                  || (state_q == UNPAUSING &&  tgt_pause_ack);
    assign expire  = waiting && (tcnt_q == TW'(TIMEOUT - 1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_d != state_q || !waiting) tcnt_q <= '0;
            else                                tcnt_q <= tcnt_q + 1'b1;
            if (expire) err_q <= 1'b1;
        end
    end
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        if (wr_ok) act_d = mr_wdata[1:0];
        unique case (state_q)
            STOPPED: begin
                if (act == ACT_RESUME || act == ACT_PAUSE) begin
                    state_d = UNRESET;
                    cnt_d   = CW'(RST_CYCLES - 1);
                end else if (act_q == ACT_STOP) begin
                    act_d = ACT_NONE;
                end
            end
            RUNNING: begin
                if (act == ACT_PAUSE || act == ACT_STOP) state_d = PAUSING;
                else if (act_q == ACT_RESUME)            act_d   = ACT_NONE;
            end
            PAUSED: begin
                if (act == ACT_RESUME) begin
                    state_d = UNPAUSING;
                end else if (act == ACT_STOP) begin
                    state_d = RESETTING;
                    cnt_d   = CW'(RST_CYCLES - 1);
                end else if (act_q == ACT_PAUSE) begin
                    act_d = ACT_NONE;
                end
            end
            PAUSING: begin
                if (tgt_pause_ack || expire) begin
                    if (act_q == ACT_STOP) begin
                        state_d = RESETTING;
                        cnt_d   = CW'(RST_CYCLES - 1);
                    end else if (tgt_pause_ack) begin
                        state_d = PAUSED;
                    end else begin
                        // abandoned pause: target keeps running
                        state_d = RUNNING;
                        act_d   = ACT_NONE;
                    end
                end
            end
            UNPAUSING: begin
                if (!tgt_pause_ack || expire) state_d = RUNNING;
            end
            UNRESET: begin
                if (cnt_q == '0)
                    state_d = (act_q == ACT_RESUME) ? UNPAUSING : PAUSED;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            RESETTING: begin
                if (cnt_q == '0) state_d = STOPPED;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = STOPPED;
        endcase
    end

    always_comb begin
        tgt_rst_d   = (state_d == STOPPED) || (state_d == RESETTING);
        tgt_preq_d  = !((state_d == RUNNING) || (state_d == UNPAUSING));
        // a write in the same cycle as a rising pause_req wins
        pause_ack_d = pause_req
                      && (pause_ack_q || (act_q == ACT_NONE && !wr_ok));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= STOPPED;
            act_q       <= (BOOT_RUNNING != 0) ? ACT_RESUME : ACT_NONE;
            cnt_q       <= '0;
            pause_ack_q <= 1'b0;
            tgt_rst_q   <= 1'b1;
            tgt_preq_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            cnt_q       <= cnt_d;
            pause_ack_q <= pause_ack_d;
            tgt_rst_q   <= tgt_rst_d;
            tgt_preq_q  <= tgt_preq_d;
        end
    end

    always_comb begin
        mr_rdata      = '0;
        mr_rdata[1:0] = act_q;
        sr_rdata      = '0;
        sr_rdata[2:0] = state_q;
        sr_rdata[8]   = err;
    end

    assign pause_ack     = pause_ack_q;
    assign tgt_rst       = tgt_rst_q;
    assign tgt_pause_req = tgt_preq_q;

endmodule

// File: tb/tb_adam_tgt_maestro.sv
// Directed bench for adam_tgt_maestro (RST_CYCLES=4, BOOT_RUNNING=1, TIMEOUT=16).
module tb_adam_tgt_maestro;

    localparam int R = 4;

    logic        clk;
    logic        rst;
    logic        mr_we;
    logic [31:0] mr_wdata;
    logic [31:0] mr_rdata;
    logic [31:0] sr_rdata;
    logic        pause_req;
    logic        pause_ack;
    logic        tgt_rst;
    logic        tgt_pause_req;
    logic        tgt_pause_ack;
    logic        mirror;
    logic        ack_man;

    int n_checks = 0;
    int n_err    = 0;
    int rst_hi   = 0;

    adam_tgt_maestro #(
        .DATA_WIDTH  (32),
        .RST_CYCLES  (R),
        .BOOT_RUNNING(1),
        .TIMEOUT     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mr_we        (mr_we),
        .mr_wdata     (mr_wdata),
        .mr_rdata     (mr_rdata),
        .sr_rdata     (sr_rdata),
        .pause_req    (pause_req),
        .pause_ack    (pause_ack),
        .tgt_rst      (tgt_rst),
        .tgt_pause_req(tgt_pause_req),
        .tgt_pause_ack(tgt_pause_ack)
    );

    assign tgt_pause_ack = mirror ? tgt_pause_req : ack_man;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (tgt_rst) rst_hi++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] v);
        mr_we    = 1'b1;
        mr_wdata = v;
        tick();
        mr_we    = 1'b0;
        mr_wdata = '0;
    endtask

    task automatic wait_idle(input int max, output int n);
        n = 0;
        while (mr_rdata != 0 && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        int c3;
        int r0;
        rst = 1'b0; mr_we = 1'b0; mr_wdata = '0;
        pause_req = 1'b0; mirror = 1'b1; ack_man = 1'b0;
        tick(); tick();
        check("rst_mr",   mr_rdata, 1);
        check("rst_sr",   sr_rdata, 0);
        check("rst_trst", tgt_rst, 1);
        check("rst_preq", tgt_pause_req, 1);
        check("rst_pack", pause_ack, 0);

        // boot: implicit RESUME
        rst = 1'b1;
        wait_idle(R + 4, n);
        check("boot_cyc",  n, 7);
        check("boot_mr",   mr_rdata, 0);
        check("boot_sr",   sr_rdata, 1);
        check("boot_trst", tgt_rst, 0);
        check("boot_preq", tgt_pause_req, 0);

        // STOP from RUNNING, immediate ack
        wr(3);
        check("stop_mr",   mr_rdata, 3);
        check("stop_sr0",  sr_rdata, 3);
        check("stop_preq", tgt_pause_req, 1);
        check("stop_trst0", tgt_rst, 0);
        tick();
        check("stop_sr1",  sr_rdata, 6);
        check("stop_trst1", tgt_rst, 1);
        repeat (R - 1) tick();
        check("stop_sr2",  sr_rdata, 6);
        tick();
        check("stop_sr3",  sr_rdata, 0);
        check("stop_mr1",  mr_rdata, 3);
        tick();
        check("stop_mr2",  mr_rdata, 0);
        check("stop_trst2", tgt_rst, 1);
        check("stop_preq2", tgt_pause_req, 1);

        // RESUME from STOPPED
        wr(1);
        check("unr_sr",   sr_rdata, 4);
        check("unr_trst", tgt_rst, 0);
        check("unr_preq", tgt_pause_req, 1);
        check("unr_mr",   mr_rdata, 1);
        wait_idle(20, n);
        check("unr_cyc",  n, 6);
        check("unr_sr2",  sr_rdata, 1);
        check("unr_preq2", tgt_pause_req, 0);

        // PAUSE with ack delayed 10 cycles
        r0 = rst_hi;
        mirror = 1'b0; ack_man = 1'b0;
        wr(2);
        check("pz_sr0", sr_rdata, 3);
        check("pz_preq", tgt_pause_req, 1);
        c3 = 0;
        repeat (9) begin
            tick();
            if (sr_rdata == 3) c3++;
        end
        check("pz_hold", c3, 9);
        ack_man = 1'b1;
        tick();
        check("pz_sr1", sr_rdata, 2);
        tick();
        check("pz_mr", mr_rdata, 0);
        mirror = 1'b1;
        wr(1);
        check("upz_sr0", sr_rdata, 5);
        check("upz_preq", tgt_pause_req, 0);
        tick();
        check("upz_sr1", sr_rdata, 1);
        tick();
        check("upz_mr", mr_rdata, 0);
        check("pz_norst", rst_hi - r0, 0);

        // dropped writes: busy and invalid code
        wr(2);
        check("drop_mr0", mr_rdata, 2);
        wr(3);
        check("drop_mr1", mr_rdata, 2);
        check("drop_sr1", sr_rdata, 2);
        tick();
        check("drop_mr2", mr_rdata, 0);
        wr(7);
        check("inv_mr", mr_rdata, 0);
        tick();
        check("inv_sr", sr_rdata, 2);
        wr(1);
        wait_idle(10, n);
        check("drop_back", n, 2);
        check("drop_sr3", sr_rdata, 1);

        // upstream pause raised together with a STOP
        pause_req = 1'b1;
        wr(3);
        check("up_mr", mr_rdata, 3);
        bad = 0;
        n = 0;
        while (mr_rdata != 0 && n < 20) begin
            if (pause_ack) bad++;
            tick();
            n++;
        end
        check("up_cyc", n, 6);
        check("up_early", bad, 0);
        check("up_ack0", pause_ack, 0);
        tick();
        check("up_ack1", pause_ack, 1);
        wr(1);
        check("up_wmr", mr_rdata, 0);
        check("up_wsr", sr_rdata, 0);
        pause_req = 1'b0;
        tick();
        check("up_ack2", pause_ack, 0);

        // reset mid-sequence
        wr(1);
        tick();
        rst = 1'b0;
        #1;
        check("mid_mr",   mr_rdata, 1);
        check("mid_sr",   sr_rdata, 0);
        check("mid_trst", tgt_rst, 1);
        check("mid_preq", tgt_pause_req, 1);
        tick();
        rst = 1'b1;
        wait_idle(R + 4, n);
        check("mid_cyc", n, 7);
        check("mid_sr2", sr_rdata, 1);

`ifdef ADAM_MAESTRO_TIMEOUT_EN
        mirror = 1'b0; ack_man = 1'b0;
        wr(3);
        check("to_sr0", sr_rdata, 3);
        repeat (15) tick();
        check("to_sr1", sr_rdata, 3);
        check("to_trst0", tgt_rst, 0);
        tick();
        check("to_sr2", sr_rdata, 32'h106);
        check("to_trst1", tgt_rst, 1);
        wait_idle(20, n);
        check("to_cyc", n, 5);
        check("to_sr3", sr_rdata, 32'h100);
`else
        check("noerr_sr", sr_rdata, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/adam_tgt_maestro.md
# adam_tgt_maestro

Per-target lifecycle sequencer sitting directly downstream of the system-configuration register file. One instance per managed target: CPU, DMA, memory, peripheral, fabric or domain. It consumes the action written to the target's MR register (RESUME/PAUSE/STOP). It then sequences that target's pause req/ack handshake and reset line, and reports completion by clearing MR. It also reports the target's state in SR.

## Interface

Parameters:
- DATA_WIDTH, 32: register data width.
- RST_CYCLES, 4: cycles `tgt_rst` is held asserted on STOP, and cycles waited after reset release on RESUME/PAUSE from STOPPED; must be ≥1.
- BOOT_RUNNING, 1: if 1, an implicit RESUME is pending out of reset.
- TIMEOUT, 1024: ack wait limit in cycles; used only with the macro in Configuration.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-low reset.
- mr_we, in, 1: single-cycle MR write strobe.
- mr_wdata, in, DATA_WIDTH: action code; 1 RESUME, 2 PAUSE, 3 STOP, other values invalid.
- mr_rdata, out, DATA_WIDTH: pending action; 0 when idle.
- sr_rdata, out, DATA_WIDTH: bits [2:0] state code, bit 8 sticky error, other bits 0.
- pause_req, in, 1: pause request from upstream, i.e. syscfg itself.
- pause_ack, out, 1: acknowledge of upstream pause.
- tgt_rst, out, 1: target reset, active-high.
- tgt_pause_req, out, 1: target pause request.
- tgt_pause_ack, in, 1: target pause acknowledge.

## Operation

- State codes: STOPPED=0, RUNNING=1, PAUSED=2, PAUSING=3, UNRESET=4, UNPAUSING=5, RESETTING=6.
- Reset values while `rst`=0:
  - state STOPPED, `tgt_rst`=1, `tgt_pause_req`=1.
  - `mr_rdata` = BOOT_RUNNING ? 1 : 0.
  - `sr_rdata`=0, `pause_ack`=0.
- Write acceptance:
  - A write is accepted only when `mr_we`=1, `mr_rdata`=0 and `pause_ack`=0. Writes while busy or upstream-paused are dropped.
  - Invalid codes (0 or >3) are dropped; `mr_rdata` stays 0.
- Transitions; the action completes when `mr_rdata` returns to 0:
  - RESUME from RUNNING, PAUSE from PAUSED, STOP from STOPPED: no-op; complete next cycle.
  - PAUSE from RUNNING: PAUSING with `tgt_pause_req`=1, wait for `tgt_pause_ack`=1, then PAUSED.
  - RESUME from PAUSED: UNPAUSING with `tgt_pause_req`=0, wait for `tgt_pause_ack`=0, then RUNNING.
  - STOP from RUNNING: PAUSING until ack, then RESETTING with `tgt_rst`=1 for RST_CYCLES, then STOPPED.
  - STOP from PAUSED: RESETTING directly.
  - RESUME from STOPPED: UNRESET with `tgt_rst`=0 for RST_CYCLES, then UNPAUSING, then RUNNING.
  - PAUSE from STOPPED: UNRESET, then PAUSED.
- In STOPPED, `tgt_rst`=1 and `tgt_pause_req`=1 always.
- Upstream pause:
  - `pause_ack` rises when `pause_req`=1 and the block is idle. If busy, the current action finishes first.
  - `pause_ack` falls when `pause_req` falls. The target state is untouched.

## Timing

- All outputs are registered; no combinational path from input to output.
- Write at edge N: `mr_rdata` holds the action, `sr_rdata` shows the transient state, and `tgt_pause_req`/`tgt_rst` change, all from edge N+1.
- Target ack sampled at edge M: next state is visible from M+1.
- RESETTING and UNRESET each last exactly RST_CYCLES cycles, counted by an internal counter sized clog2(RST_CYCLES+1).
- No-op completion: `mr_rdata` returns to 0 at edge N+2.
- STOP from RUNNING with an immediate ack: `mr_rdata`=0 at N+3+RST_CYCLES.
- Simultaneous `mr_we` and `pause_req` rising while idle: the write wins; `pause_ack` waits for completion.
- Reset mid-sequence: immediately returns to the reset values; any pending action is lost except the BOOT_RUNNING RESUME.

## Configuration

- ADAM_MAESTRO_TIMEOUT_EN defined:
  - A counter bounds every ack wait at TIMEOUT cycles.
  - On expiry in PAUSING during a STOP, proceed to RESETTING.
  - On expiry in PAUSING during a PAUSE, drop `tgt_pause_req` and return to RUNNING.
  - On expiry in UNPAUSING, enter RUNNING.
  - Every expiry sets sticky SR bit 8 and completes the action. The bit clears only on `rst`.
- Macro undefined: waits are unbounded; SR bit 8 reads 0; no counter logic is synthesized.

## Test plan

- Boot, BOOT_RUNNING=1, ack mirrors req: `mr_rdata` 1→0 within RST_CYCLES+4 cycles; `sr_rdata`=1, `tgt_rst`=0.
- From RUNNING, write 3: `tgt_pause_req`=1, then `tgt_rst`=1 for ≥4 cycles; `mr_rdata`→0, `sr_rdata`=0. Then write 1: `tgt_rst`=0, `tgt_pause_req`=0, `sr_rdata`=1.
- From RUNNING, write 2 with ack delayed 10 cycles: `sr_rdata`=3 for 10 cycles, then 2; write 1 → `sr_rdata`=1, `tgt_rst` never asserted.
- Write 3 while `mr_rdata`≠0, and write 7 while idle: both dropped; state and `mr_rdata` unchanged.
- `pause_req`=1 during a STOP: `pause_ack` rises only after `mr_rdata`=0; a write of 1 while `pause_ack`=1 is ignored; `pause_ack` falls the cycle after `pause_req` drops.
- ADAM_MAESTRO_TIMEOUT_EN with TIMEOUT=16, ack tied 0, write 3: after 16 cycles `tgt_rst`=1, SR bit 8=1, `mr_rdata`→0.
